// File: rtl/training_pkg.sv
// Shared state encoding, watchdog sizing and config legality check for the training sequencer.
package training_pkg;

  localparam logic [2:0] ENC_IDLE        = 3'd0;
  localparam logic [2:0] ENC_FP_START    = 3'd1;
  localparam logic [2:0] ENC_FP_WAIT     = 3'd2;
  localparam logic [2:0] ENC_BP_START    = 3'd3;
  localparam logic [2:0] ENC_BP_WAIT     = 3'd4;
  localparam logic [2:0] ENC_NEXT_SAMPLE = 3'd5;
  localparam logic [2:0] ENC_DONE        = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE        = ENC_IDLE,
    ST_FP_START    = ENC_FP_START,
    ST_FP_WAIT     = ENC_FP_WAIT,
    ST_BP_START    = ENC_BP_START,
    ST_BP_WAIT     = ENC_BP_WAIT,
    ST_NEXT_SAMPLE = ENC_NEXT_SAMPLE,
    ST_DONE        = ENC_DONE
  } state_t;

  localparam int TIMEOUT_WIDTH_DEFAULT = 16;
  localparam int WD_LIMIT_DEFAULT      = (1 << TIMEOUT_WIDTH_DEFAULT) - 1;

  // Number of wait cycles tolerated before the watchdog fires.
  function automatic int wd_limit(input int width);
    return (1 << width) - 1;
  endfunction

  function automatic logic cfg_legal(input int nl, input int ns, input int ne,
                                     input int layer_max, input int max_samples);
    return (nl >= 1) && (nl <= layer_max) && (ns >= 1) && (ns <= max_samples) && (ne >= 1);
  endfunction

endpackage

// File: rtl/training_sequencer_if.sv
// Engine-side handshake of the training sequencer: start pulses, completion pulses and indices.
interface training_sequencer_if #(
  parameter int LAYER_ADDR_WIDTH = 2,
  parameter int SAMPLE_ADDR_SIZE = 14,
  parameter int EPOCH_WIDTH      = 8
);
  logic                        fp_start;
  logic                        fp_valid;
  logic                        bp_start;
  logic                        bp_valid;
  logic                        bp_error;
  logic                        stack_wr_en;
  logic [LAYER_ADDR_WIDTH-1:0] current_layer;
  logic [SAMPLE_ADDR_SIZE-1:0] current_sample;
  logic [EPOCH_WIDTH-1:0]      current_epoch;

  modport master (
    output fp_start, bp_start, stack_wr_en, current_layer, current_sample, current_epoch,
    input  fp_valid, bp_valid, bp_error
  );

  modport slave (
    input  fp_start, bp_start, stack_wr_en, current_layer, current_sample, current_epoch,
    output fp_valid, bp_valid, bp_error
  );
endinterface

// File: rtl/engine_watchdog.sv
// Counts consecutive wait cycles; expired is combinational and asserts on the last tolerated cycle.
module engine_watchdog import training_pkg::*; #(
  parameter int WIDTH = TIMEOUT_WIDTH_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam logic [WIDTH-1:0] LAST_CNT = WIDTH'(wd_limit(WIDTH) - 1);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign expired = enable && (cnt_q == LAST_CNT);
endmodule

// File: rtl/training_sequencer.sv
// Sequences FP up and BP down the layers per sample per epoch; engine handshakes are start/valid
// pulses with no backpressure, guarded by a watchdog; abort returns to IDLE next cycle.
module training_sequencer import training_pkg::*; #(
  parameter int LAYER_ADDR_WIDTH = 2,
  parameter int LAYER_MAX        = 3,
  parameter int SAMPLE_ADDR_SIZE = 14,
  parameter int MAX_SAMPLES      = 10000,
  parameter int EPOCH_WIDTH      = 8,
  parameter int ERR_COUNT_WIDTH  = 16,
  parameter int TIMEOUT_WIDTH    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        mode_infer,
  input  logic [LAYER_ADDR_WIDTH:0]   num_layers,
  input  logic [SAMPLE_ADDR_SIZE:0]   num_samples,
  input  logic [EPOCH_WIDTH-1:0]      num_epochs,
  training_sequencer_if.master        eng,
  output logic                        busy,
  output logic                        done,
  output logic                        cfg_error,
  output logic                        timeout,
  output logic [ERR_COUNT_WIDTH-1:0]  err_count
);
  localparam int LW = LAYER_ADDR_WIDTH;
  localparam int SW = SAMPLE_ADDR_SIZE;
  localparam int EW = EPOCH_WIDTH;
  localparam int CW = ERR_COUNT_WIDTH;

  state_t          state_q, state_d;
  logic [LW-1:0]   layer_q, layer_d;
  logic [SW-1:0]   sample_q, sample_d;
  logic [EW-1:0]   epoch_q, epoch_d;
  logic [LW:0]     nl_q, nl_d;
  logic [SW:0]     ns_q, ns_d;
  logic [EW-1:0]   ne_q, ne_d;
  logic            infer_q, infer_d;
  logic            fin_q, fin_d;
  logic            cfg_err_q, cfg_err_d;
  logic            tmo_q, tmo_d;
  logic [CW-1:0]   err_q, err_d;
  logic            advance;
  logic            wd_en, wd_expired;
  logic            more_layers, more_samples, more_epochs;

  assign more_layers  = {1'b0, layer_q} < (nl_q - (LW+1)'(1));
  assign more_samples = {1'b0, sample_q} < (ns_q - (SW+1)'(1));
  assign more_epochs  = epoch_q < (ne_q - EW'(1));

  assign wd_en = (state_q == ST_FP_WAIT) || (state_q == ST_BP_WAIT);

  engine_watchdog #(.WIDTH(TIMEOUT_WIDTH)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (!wd_en),
    .enable  (wd_en),
    .expired (wd_expired)
  );

  always_comb begin
    state_d   = state_q;
    layer_d   = layer_q;
    sample_d  = sample_q;
    epoch_d   = epoch_q;
    nl_d      = nl_q;
    ns_d      = ns_q;
    ne_d      = ne_q;
    infer_d   = infer_q;
    fin_d     = fin_q;
    cfg_err_d = cfg_err_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    advance   = 1'b0;
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            nl_d      = num_layers;
            ns_d      = num_samples;
            ne_d      = num_epochs;
            infer_d   = mode_infer;
            layer_d   = '0;
            sample_d  = '0;
            epoch_d   = '0;
            fin_d     = 1'b0;
            tmo_d     = 1'b0;
            err_d     = '0;
            cfg_err_d = !cfg_legal(int'(num_layers), int'(num_samples), int'(num_epochs),
                                   LAYER_MAX, MAX_SAMPLES);
            if (!cfg_err_d) state_d = ST_FP_START;
          end
        end
        ST_FP_START: state_d = ST_FP_WAIT;
        ST_FP_WAIT: begin
          if (eng.fp_valid) begin
            if (more_layers) begin
              layer_d = layer_q + LW'(1);
              state_d = ST_FP_START;
            end else if (infer_q || (nl_q == (LW+1)'(1))) begin
              advance = 1'b1;
              state_d = ST_NEXT_SAMPLE;
            end else begin
              state_d = ST_BP_START;
            end
          end else if (wd_expired) begin
            tmo_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_BP_START: state_d = ST_BP_WAIT;
        ST_BP_WAIT: begin
          if (eng.bp_valid) begin
            if (eng.bp_error && (err_q != '1)) err_d = err_q + CW'(1);
            if (layer_q == LW'(1)) begin
              advance = 1'b1;
              state_d = ST_NEXT_SAMPLE;
            end else begin
              layer_d = layer_q - LW'(1);
              state_d = ST_BP_START;
            end
          end else if (wd_expired) begin
            tmo_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_NEXT_SAMPLE: state_d = fin_q ? ST_DONE : ST_FP_START;
        ST_DONE:        state_d = ST_IDLE;
        default:        state_d = ST_IDLE;
      endcase
      // Indices move on entry to NEXT_SAMPLE so the BRAM address leads the next fp_start by a cycle.
      if (advance) begin
        layer_d = '0;
        if (more_samples) begin
          sample_d = sample_q + SW'(1);
        end else begin
          sample_d = '0;
          if (more_epochs) epoch_d = epoch_q + EW'(1);
          else             fin_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      layer_q   <= '0;
      sample_q  <= '0;
      epoch_q   <= '0;
      nl_q      <= '0;
      ns_q      <= '0;
      ne_q      <= '0;
      infer_q   <= 1'b0;
      fin_q     <= 1'b0;
      cfg_err_q <= 1'b0;
      tmo_q     <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      layer_q   <= layer_d;
      sample_q  <= sample_d;
      epoch_q   <= epoch_d;
      nl_q      <= nl_d;
      ns_q      <= ns_d;
      ne_q      <= ne_d;
      infer_q   <= infer_d;
      fin_q     <= fin_d;
      cfg_err_q <= cfg_err_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
    end
  end

  assign eng.fp_start       = (state_q == ST_FP_START);
  assign eng.bp_start       = (state_q == ST_BP_START);
  assign eng.stack_wr_en    = eng.fp_valid && (state_q == ST_FP_WAIT) && !abort;
  assign eng.current_layer  = layer_q;
  assign eng.current_sample = sample_q;
  assign eng.current_epoch  = epoch_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE) && !abort;
  assign cfg_error = cfg_err_q;
  assign timeout   = tmo_q;
  assign err_count = err_q;
endmodule

// File: tb/tb_training_sequencer.sv
// Randomised bench: a loop-nest reference model queues expected engine events, a monitor pops them.
module tb_training_sequencer;
  localparam int LW = 2;
  localparam int SW = 14;
  localparam int EW = 8;
  localparam int CW = 2;
  localparam int TW = 4;
  localparam int K_FP = 0, K_WR = 1, K_BP = 2, K_DONE = 3;

  logic clk = 1'b0;
  logic rst, start, abort, mode_infer;
  logic [LW:0]   num_layers;
  logic [SW:0]   num_samples;
  logic [EW-1:0] num_epochs;
  logic busy, done, cfg_error, timeout;
  logic [CW-1:0] err_count;

  training_sequencer_if #(.LAYER_ADDR_WIDTH(LW), .SAMPLE_ADDR_SIZE(SW), .EPOCH_WIDTH(EW)) eng();

  training_sequencer #(
    .LAYER_ADDR_WIDTH(LW), .LAYER_MAX(3), .SAMPLE_ADDR_SIZE(SW), .MAX_SAMPLES(10000),
    .EPOCH_WIDTH(EW), .ERR_COUNT_WIDTH(CW), .TIMEOUT_WIDTH(TW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode_infer(mode_infer),
    .num_layers(num_layers), .num_samples(num_samples), .num_epochs(num_epochs),
    .eng(eng), .busy(busy), .done(done), .cfg_error(cfg_error), .timeout(timeout),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct { int kind; int layer; int sample; int epoch; } ev_t;
  ev_t exp_q[$];
  int total = 0, bad = 0;
  int err_pct = 0, lat_fixed = 4, stray_req = 0, err_total = 0;
  bit withhold_fp = 1'b0, abort_on_bp = 1'b0;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  function automatic void push(input int k, input int l, input int s, input int e);
    ev_t ev;
    ev.kind = k; ev.layer = l; ev.sample = s; ev.epoch = e;
    exp_q.push_back(ev);
  endfunction

  // Reference schedule: FP each layer upward, BP each layer above 0 downward, per sample per epoch.
  function automatic void build_expected(input int nl, input int ns, input int ne, input bit inf);
    for (int e = 0; e < ne; e++)
      for (int s = 0; s < ns; s++) begin
        for (int l = 0; l < nl; l++) begin
          push(K_FP, l, s, e);
          push(K_WR, l, s, e);
        end
        if (!inf)
          for (int l = nl - 1; l >= 1; l--) push(K_BP, l, s, e);
      end
    push(K_DONE, 0, 0, ne - 1);
  endfunction

  function automatic int pick_lat();
    return (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 6));
  endfunction

  function automatic int sat(input int x);
    return (x > 3) ? 3 : x;
  endfunction

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst && (eng.fp_start || eng.bp_start || eng.stack_wr_en || done)) begin
        ev_t o, w;
        o.kind   = eng.fp_start ? K_FP : eng.stack_wr_en ? K_WR : eng.bp_start ? K_BP : K_DONE;
        o.layer  = int'(eng.current_layer);
        o.sample = int'(eng.current_sample);
        o.epoch  = int'(eng.current_epoch);
        if (exp_q.size() == 0) begin
          chk("unexpected_event_kind", o.kind, -1);
        end else begin
          w = exp_q.pop_front();
          chk("event_kind", o.kind, w.kind);
          chk("event_layer", o.layer, w.layer);
          chk("event_sample", o.sample, w.sample);
          chk("event_epoch", o.epoch, w.epoch);
        end
      end
    end
  end

  initial begin : engine
    int fp_cd, bp_cd, stray_done;
    fp_cd = 0; bp_cd = 0; stray_done = 0;
    eng.fp_valid = 1'b0; eng.bp_valid = 1'b0; eng.bp_error = 1'b0; abort = 1'b0;
    forever begin
      @(posedge clk); #1;
      eng.fp_valid = 1'b0; eng.bp_valid = 1'b0; eng.bp_error = 1'b0; abort = 1'b0;
      if (fp_cd > 0) begin
        fp_cd--;
        if (fp_cd == 0) eng.fp_valid = 1'b1;
      end
      if (bp_cd > 0) begin
        bp_cd--;
        if (bp_cd == 0) begin
          eng.bp_valid = 1'b1;
          eng.bp_error = ($urandom_range(0, 99) < err_pct);
          if (abort_on_bp) abort = 1'b1;
          else if (eng.bp_error) err_total++;
        end
      end
      if (stray_req != stray_done) begin
        eng.fp_valid = 1'b1;
        stray_done = stray_req;
      end
      if (eng.fp_start && !withhold_fp) fp_cd = pick_lat();
      if (eng.bp_start) bp_cd = pick_lat();
    end
  end

  task automatic start_run(input int nl, input int ns, input int ne, input bit inf);
    @(posedge clk); #1;
    num_layers = (LW+1)'(nl); num_samples = (SW+1)'(ns); num_epochs = EW'(ne);
    mode_infer = inf; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("run_finished_in_budget", int'(busy), 0);
  endtask

  task automatic run_cfg(input int nl, input int ns, input int ne, input bit inf,
                         input int pct, input int lat);
    bit legal;
    int base;
    legal = (nl >= 1) && (nl <= 3) && (ns >= 1) && (ns <= 10000) && (ne >= 1);
    err_pct = pct; lat_fixed = lat;
    repeat (10) @(posedge clk);
    base = err_total;
    if (legal) build_expected(nl, ns, ne, inf);
    start_run(nl, ns, ne, inf);
    if (legal) begin
      wait_idle(20000);
      chk("events_left", exp_q.size(), 0);
      chk("err_count", int'(err_count), sat(err_total - base));
      chk("cfg_error_clear", int'(cfg_error), 0);
      chk("timeout_clear", int'(timeout), 0);
      chk("final_epoch", int'(eng.current_epoch), ne - 1);
      chk("final_sample", int'(eng.current_sample), 0);
    end else begin
      repeat (5) @(negedge clk);
      chk("cfg_error_set", int'(cfg_error), 1);
      chk("busy_on_bad_cfg", int'(busy), 0);
    end
  endtask

  task automatic watchdog_test();
    int cs, ct;
    cs = -1; ct = -1;
    withhold_fp = 1'b1; lat_fixed = 4;
    repeat (10) @(posedge clk);
    push(K_FP, 0, 0, 0);
    start_run(2, 1, 1, 0);
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (cs < 0 && eng.fp_start) cs = n;
      if (ct < 0 && timeout) ct = n;
    end
    chk("wd_cycles_to_timeout", ct - cs, 16);
    chk("timeout_set", int'(timeout), 1);
    chk("busy_after_timeout", int'(busy), 0);
    chk("events_left_wd", exp_q.size(), 0);
    withhold_fp = 1'b0;
  endtask

  task automatic abort_test();
    int ab_n, saw;
    abort_on_bp = 1'b1; err_pct = 100; lat_fixed = 3;
    repeat (10) @(posedge clk);
    push(K_FP, 0, 0, 0); push(K_WR, 0, 0, 0);
    push(K_FP, 1, 0, 0); push(K_WR, 1, 0, 0);
    push(K_BP, 1, 0, 0);
    start_run(2, 1, 1, 0);
    ab_n = -1;
    for (int n = 0; n < 100 && ab_n < 0; n++) begin
      @(negedge clk);
      if (abort) ab_n = n;
    end
    chk("abort_reached", int'(ab_n >= 0), 1);
    @(negedge clk);
    chk("busy_after_abort", int'(busy), 0);
    chk("err_after_abort", int'(err_count), 0);
    chk("events_left_abort", exp_q.size(), 0);
    abort_on_bp = 1'b0;
    saw = 0;
    stray_req++;
    repeat (3) begin
      @(negedge clk);
      saw = saw | int'(eng.stack_wr_en);
    end
    chk("stray_fp_valid_write", saw, 0);
  endtask

  task automatic reset_midrun_test();
    err_pct = 0; lat_fixed = 4;
    repeat (10) @(posedge clk);
    build_expected(3, 2, 1, 0);
    start_run(3, 2, 1, 0);
    repeat (12) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("busy_after_reset", int'(busy), 0);
    chk("layer_after_reset", int'(eng.current_layer), 0);
    chk("sample_after_reset", int'(eng.current_sample), 0);
    repeat (10) @(negedge clk);
  endtask

  initial begin : main
    rst = 1'b0; start = 1'b0; mode_infer = 1'b0;
    num_layers = '0; num_samples = '0; num_epochs = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_cfg_error", int'(cfg_error), 0);
    chk("reset_timeout", int'(timeout), 0);
    chk("reset_err_count", int'(err_count), 0);
    chk("reset_fp_start", int'(eng.fp_start), 0);
    chk("reset_layer", int'(eng.current_layer), 0);
    chk("reset_epoch", int'(eng.current_epoch), 0);

    run_cfg(3, 2, 1, 0, 0, 4);
    run_cfg(2, 3, 2, 1, 0, 4);
    run_cfg(0, 1, 1, 0, 0, 4);
    run_cfg(4, 1, 1, 0, 0, 4);
    run_cfg(2, 0, 1, 0, 0, 4);
    run_cfg(2, 1, 0, 0, 0, 4);
    run_cfg(1, 10001, 1, 0, 0, 4);
    run_cfg(1, 1, 1, 0, 0, 4);
    for (int i = 0; i < 8; i++)
      run_cfg(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), int'($urandom_range(1, 2)),
              1'($urandom_range(0, 1)), 40, 0);
    watchdog_test();
    run_cfg(2, 1, 1, 0, 0, 2);
    abort_test();
    run_cfg(3, 3, 1, 0, 100, 2);
    reset_midrun_test();
    run_cfg(2, 2, 1, 0, 50, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
